// File: rtl/ssd_scan_driver_pkg.sv
// ssd_pkg: glyph codes and shared types for the lock display bus
// Used by the scan driver, its glyph ROM and the lock FSM that produces codes.
package ssd_pkg;
    typedef logic [4:0] glyph_t;
    typedef logic [6:0] seg_t;
    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;
    typedef struct packed {
        glyph_t [3:0] code;
        logic [3:0]   blank;
        logic [3:0]   blink;
    } snap_t;
    localparam glyph_t GLYPH_C     = 5'd12;
    localparam glyph_t GLYPH_D     = 5'd13;
    localparam glyph_t GLYPH_E     = 5'd14;
    localparam glyph_t GLYPH_L     = 5'd16;
    localparam glyph_t GLYPH_DASH  = 5'd17;
    localparam glyph_t GLYPH_BLANK = 5'd18;
    localparam glyph_t GLYPH_P     = 5'd19;
    localparam glyph_t GLYPH_N     = 5'd20;
    localparam glyph_t GLYPH_H     = 5'd21;
    localparam glyph_t GLYPH_U     = 5'd22;
    localparam glyph_t GLYPH_T     = 5'd23;
    localparam snap_t SNAP_RST = '{code: {4{GLYPH_BLANK}}, blank: 4'b0000, blink: 4'b0000};
    function automatic logic [3:0] an_for(dig_t d);
        return ~(4'b0001 << d);
    endfunction
endpackage

// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: display bus between the lock FSM and the scan driver
// master: drives code/blank_mask/blink_mask, sees AN/seven_out/frame_done/blink_phase
// slave:  the scan driver
interface ssd_scan_driver_if;
    import ssd_pkg::*;
    logic [19:0] code;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  AN;
    seg_t        seven_out;
    logic        frame_done;
    logic        blink_phase;
    modport master (
        output code, blank_mask, blink_mask,
        input  AN, seven_out, frame_done, blink_phase
    );
    modport slave (
        input  code, blank_mask, blink_mask,
        output AN, seven_out, frame_done, blink_phase
    );
endinterface

// File: rtl/ssd_scan_driver_glyph_rom.sv
// ssd_glyph_rom: 5-bit glyph code to active-high {a,b,c,d,e,f,g} segments
// Ports: code in 5, seg out 7. Codes 24-31 render blank.
module ssd_glyph_rom
    import ssd_pkg::*;
(
    input  glyph_t code,
    output seg_t   seg
);
    always_comb begin
        case (code)
            5'd0:        seg = 7'b1111110;
            5'd1:        seg = 7'b0110000;
            5'd2:        seg = 7'b1101101;
            5'd3:        seg = 7'b1111001;
            5'd4:        seg = 7'b0110011;
            5'd5:        seg = 7'b1011011;
            5'd6:        seg = 7'b1011111;
            5'd7:        seg = 7'b1110000;
            5'd8:        seg = 7'b1111111;
            5'd9:        seg = 7'b1111011;
            5'd10:       seg = 7'b1110111;
            5'd11:       seg = 7'b0011111;
            GLYPH_C:     seg = 7'b1001110;
            GLYPH_D:     seg = 7'b0111101;
            GLYPH_E:     seg = 7'b1001111;
            5'd15:       seg = 7'b1000111;
            GLYPH_L:     seg = 7'b0001110;
            GLYPH_DASH:  seg = 7'b0000001;
            GLYPH_P:     seg = 7'b1100111;
            GLYPH_N:     seg = 7'b0010101;
            GLYPH_H:     seg = 7'b0110111;
            GLYPH_U:     seg = 7'b0111110;
            GLYPH_T:     seg = 7'b0001111;
            default:     seg = 7'b0000000;
        endcase
    end
endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: four-digit multiplexed seven-segment driver with frame-atomic capture
// Ports: clk, rst (async, active-low), bus (slave): code/blank_mask/blink_mask in,
//        AN/seven_out (active-low, registered), frame_done pulse, blink_phase out.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input logic clk,
    input logic rst,
    ssd_scan_driver_if.slave bus
);
    localparam int SW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRM_ONE   = FW'(1);
    logic [SW-1:0] slot_cnt, slot_nxt;
    logic [FW-1:0] frm, frm_nxt;
    dig_t          dig, dig_nxt;
    snap_t         snap, snap_nxt;
    logic          phase, phase_nxt;
    logic          done, done_nxt;
    logic [3:0]    an, an_nxt;
    seg_t          seg_q, seg_nxt, glyph;
    logic          tc, cap, dark;
    ssd_glyph_rom rom (
        .code (snap.code[dig]),
        .seg  (glyph)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            frm      <= '0;
            dig      <= DIG3;
            snap     <= SNAP_RST;
            phase    <= 1'b0;
            done     <= 1'b0;
            an       <= 4'b1111;
            seg_q    <= 7'b1111111;
        end else begin
            slot_cnt <= slot_nxt;
            frm      <= frm_nxt;
            dig      <= dig_nxt;
            snap     <= snap_nxt;
            phase    <= phase_nxt;
            done     <= done_nxt;
            an       <= an_nxt;
            seg_q    <= seg_nxt;
        end
    end
    // The pins are rendered from the current digit one cycle late, so a capture and
    // blink toggle on the digit-0 TC both land on the next frame's first digit.
    always_comb begin
        tc        = slot_cnt == SLOT_LAST;
        cap       = tc && dig == DIG0;
        slot_nxt  = tc ? '0 : slot_cnt + SLOT_ONE;
        dig_nxt   = tc ? dig_t'(dig - 2'd1) : dig;
        snap_nxt  = cap ? {bus.code, bus.blank_mask, bus.blink_mask} : snap;
        frm_nxt   = cap ? (frm == FRM_LAST ? '0 : frm + FRM_ONE) : frm;
        phase_nxt = phase ^ (cap && frm == FRM_LAST);
        done_nxt  = cap;
        dark      = snap.blank[dig] | (snap.blink[dig] & phase);
        an_nxt    = dark ? 4'b1111 : an_for(dig);
        seg_nxt   = dark ? 7'b1111111 : ~glyph;
    end
    assign bus.AN          = an;
    assign bus.seven_out   = seg_q;
    assign bus.frame_done  = done;
    assign bus.blink_phase = phase;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed frame-by-frame check of the scan driver
module tb_ssd_scan_driver;
    import ssd_pkg::*;
    localparam logic [19:0] BLANK4 = {5'd18, 5'd18, 5'd18, 5'd18};
    localparam logic [19:0] CLSD   = {5'd12, 5'd16, 5'd5, 5'd13};
    localparam logic [19:0] OPEN   = {5'd0, 5'd19, 5'd14, 5'd20};
    localparam logic [19:0] D3     = {5'd17, 5'd17, 5'd17, 5'd3};
    localparam logic [19:0] D9     = {5'd17, 5'd17, 5'd17, 5'd9};
    localparam logic [19:0] D27    = {5'd17, 5'd17, 5'd27, 5'd9};
    localparam logic [6:0] SEG [32] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
        7'b0001110, 7'b0000001, 7'b0000000, 7'b1100111, 7'b0010101, 7'b0110111, 7'b0111110, 7'b0001111,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    ssd_scan_driver_if bus();
    ssd_scan_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    // posedges since reset release: capture k happens on posedge 16k, blink toggles every 32
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic check_reset(input string tag);
        check({tag, " an"}, 32'(bus.AN), 32'hf);
        check({tag, " seg"}, 32'(bus.seven_out), 32'h7f);
        check({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
        check({tag, " blink_phase"}, 32'(bus.blink_phase), 32'h0);
    endtask
    // Checks one 16-cycle frame against snapshot c/bl/bk; at sample chg new inputs are driven.
    task automatic check_frame(input string tag, input logic [19:0] c, input logic [3:0] bl,
                               input logic [3:0] bk, input int chg, input logic [19:0] nc,
                               input logic [3:0] nbl, input logic [3:0] nbk);
        logic fph, dark;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int d;
        fph = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = 3 - k / 4;
            if (k == 0) fph = ((cyc - 1) / 32) % 2 == 1;
            dark = bl[d] | (bk[d] & fph);
            exp_an = dark ? 4'hf : ~(4'b0001 << d);
            exp_seg = dark ? 7'h7f : ~SEG[c[d*5 +: 5]];
            check($sformatf("%s an d%0d s%0d", tag, d, k % 4), 32'(bus.AN), 32'(exp_an));
            check($sformatf("%s seg d%0d s%0d", tag, d, k % 4), 32'(bus.seven_out), 32'(exp_seg));
            check($sformatf("%s frame_done k%0d", tag, k), 32'(bus.frame_done), 32'(k == 15));
            check($sformatf("%s blink_phase k%0d", tag, k), 32'(bus.blink_phase), 32'((cyc / 32) % 2));
            if (k == chg) begin
                bus.code = nc;
                bus.blank_mask = nbl;
                bus.blink_mask = nbk;
            end
        end
    endtask
    initial begin
        bus.code = CLSD;
        bus.blank_mask = 4'b0000;
        bus.blink_mask = 4'b0000;
        #1 rst = 1'b0;
        #11 check_reset("reset");
        @(negedge clk);
        #2 rst = 1'b1;
        check_frame("f0 rstsnap", BLANK4, 4'b0000, 4'b0000, -1, 20'h0, 4'h0, 4'h0);
        check_frame("f1 clsd", CLSD, 4'b0000, 4'b0000, 14, OPEN, 4'b0011, 4'b0000);
        check_frame("f2 blank", OPEN, 4'b0011, 4'b0000, 14, OPEN, 4'b0000, 4'b1000);
        check_frame("f3 blink", OPEN, 4'b0000, 4'b1000, -1, 20'h0, 4'h0, 4'h0);
        check_frame("f4 blink", OPEN, 4'b0000, 4'b1000, -1, 20'h0, 4'h0, 4'h0);
        check_frame("f5 blink", OPEN, 4'b0000, 4'b1000, -1, 20'h0, 4'h0, 4'h0);
        check_frame("f6 blink", OPEN, 4'b0000, 4'b1000, 14, D3, 4'b0000, 4'b0000);
        check_frame("f7 tear", D3, 4'b0000, 4'b0000, 5, D9, 4'b0000, 4'b0000);
        check_frame("f8 next", D9, 4'b0000, 4'b0000, 14, D27, 4'b0000, 4'b0000);
        check_frame("f9 code27", D27, 4'b0000, 4'b0000, -1, 20'h0, 4'h0, 4'h0);
        repeat (10) @(negedge clk);
        check("pre-reset an", 32'(bus.AN), 32'hd);
        check("pre-reset seg", 32'(bus.seven_out), 32'h7f);
        check("pre-reset blink_phase", 32'(bus.blink_phase), 32'h1);
        #2 rst = 1'b0;
        #1 check_reset("midslot reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        check_frame("r0 rstsnap", BLANK4, 4'b0000, 4'b0000, -1, 20'h0, 4'h0, 4'h0);
        check_frame("r1 code27", D27, 4'b0000, 4'b0000, -1, 20'h0, 4'h0, 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
